spi_slave: RTL and testbench

SPI slave (target) core: the far end of the bus driven by the team's `spi` master. Receives bytes on MOSI and returns bytes on MISO under master-supplied SCK/SS_n, buffering both directions in 4-entry FIFOs toward a local host. Supports all four CPOL/CPHA modes, MSB first, 8-bit frames, with an interrupt-count scheme mirroring the master (irq after `icnt_i`+1 completed bytes). SPI pins are asynchronous to `clk_i` and are oversampled.

---
 rtl/spi_slave.sv | 217 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target core: oversampled SCK/SS_n/MOSI, all four CPOL/CPHA modes,
// MSB-first 8-bit frames, 4-entry TX and RX FIFOs toward the local host,
// and an interrupt after icnt_i+1 completed bytes.
//
// Host FIFO handshake: tx_we_i/rx_re_i are single-cycle strobes qualified by
// tx_full_o/rx_empty_o; a push on full or a pop on empty is dropped (push on
// full still lands when a pop frees a slot in the same cycle).
module spi_slave (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spe_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic [1:0] icnt_i,
    input  logic       sck_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_dat_i,
    input  logic       tx_we_i,
    output logic       tx_full_o,
    output logic [7:0] rx_dat_o,
    input  logic       rx_re_i,
    output logic       rx_empty_o,
    input  logic       clr_i,
    output logic       irq_o,
    output logic       rx_ovf_o,
    output logic       tx_udr_o,
    output logic       wcol_o,
    output logic [1:0] state_o,
    output logic [2:0] bcnt_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [1:0] state;
    logic [2:0] bcnt;
    logic [7:0] treg, rreg;
    logic       cpol_r, cpha_r, skip;
    logic       sck_s1, sck_s2, sck_s3, ss_s1, ss_s2, ss_s3, mosi_s1, mosi_s2;
    logic [1:0] tcnt;
    logic       tcnt_vld;

    logic [7:0] tx_mem [4];
    logic [7:0] rx_mem [4];
    logic [1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [2:0] tx_cnt, rx_cnt;

    // Pin synchronizers plus one extra stage on sck/ss_n for edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {sck_s1, sck_s2, sck_s3} <= 3'b000;
            {ss_s1, ss_s2, ss_s3}    <= 3'b111;
            {mosi_s1, mosi_s2}       <= 2'b00;
        end else begin
            {sck_s1, sck_s2, sck_s3} <= {sck_i, sck_s1, sck_s2};
            {ss_s1, ss_s2, ss_s3}    <= {ss_n_i, ss_s1, ss_s2};
            {mosi_s1, mosi_s2}       <= {mosi_i, mosi_s1};
        end
    end

    logic       sck_edge, lead_e, trail_e, sample_e, shift_e;
    logic       ss_fall, ss_rise, byte_done;
    logic       tx_pop, tx_have, tx_push_ok, tx_pop_ok;
    logic       rx_pop_ok, rx_push_ok;
    logic [7:0] tx_next, rx_byte;
    logic [1:0] tcnt_eff;

    // Leading edge moves sck away from its idle level; CPHA picks which edge samples
    assign sck_edge  = sck_s2 ^ sck_s3;
    assign lead_e    = sck_edge & (sck_s2 ^ cpol_r);
    assign trail_e   = sck_edge & ~(sck_s2 ^ cpol_r);
    assign ss_fall   = ~ss_s2 & ss_s3;
    assign ss_rise   = ss_s2 & ~ss_s3;
    assign sample_e  = (state == S_SHIFT) & ~ss_rise & (cpha_r ? trail_e : lead_e);
    assign shift_e   = (state == S_SHIFT) & ~ss_rise & (cpha_r ? lead_e : trail_e);
    assign byte_done = sample_e & (bcnt == 3'd0);
    assign rx_byte   = {rreg[6:0], mosi_s2};

    // The shift register is refilled at select and at every byte completion
    assign tx_pop     = ((state == S_LOAD) & ~ss_rise) | byte_done;
    assign tx_have    = (tx_cnt != 3'd0);
    assign tx_next    = tx_have ? tx_mem[tx_rd] : 8'h00;
    assign tx_pop_ok  = tx_pop & tx_have;
    assign tx_push_ok = tx_we_i & ((tx_cnt != 3'd4) | tx_pop_ok);
    assign rx_pop_ok  = rx_re_i & (rx_cnt != 3'd0);
    assign rx_push_ok = byte_done & ((rx_cnt != 3'd4) | rx_pop_ok);
    // Until the first completion after reset/disable, the count tracks icnt_i
    assign tcnt_eff   = tcnt_vld ? tcnt : icnt_i;

    assign miso_oe_o  = (state != S_IDLE);
    assign tx_full_o  = (tx_cnt == 3'd4);
    assign rx_empty_o = (rx_cnt == 3'd0);
    assign rx_dat_o   = rx_empty_o ? 8'h00 : rx_mem[rx_rd];
    assign state_o    = state;
    assign bcnt_o     = bcnt;

    // Transfer FSM: select, load, then sample/shift on the mode-selected edges
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            bcnt   <= 3'd7;
            treg   <= 8'h00;
            rreg   <= 8'h00;
            miso_o <= 1'b0;
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            skip   <= 1'b0;
        end else if (!spe_i) begin
            state  <= S_IDLE;
            bcnt   <= 3'd7;
            miso_o <= 1'b0;
            skip   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (ss_rise) begin
                        state  <= S_IDLE;
                        miso_o <= 1'b0;
                    end else begin
                        treg   <= tx_next;
                        miso_o <= tx_next[7];
                        skip   <= cpha_r;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ss_rise) begin
                        state  <= S_IDLE;
                        bcnt   <= 3'd7;
                        miso_o <= 1'b0;
                    end else if (sample_e) begin
                        rreg <= rx_byte;
                        bcnt <= bcnt - 3'd1;
                        if (bcnt == 3'd0) begin
                            // Next byte's MSB goes out now; its first shift point is skipped
                            treg   <= tx_next;
                            miso_o <= tx_next[7];
                            skip   <= 1'b1;
                        end
                    end else if (shift_e) begin
                        if (skip) begin
                            skip <= 1'b0;
                        end else begin
                            treg   <= {treg[6:0], 1'b0};
                            miso_o <= treg[6];
                        end
                    end
                end
                default: begin
                    bcnt <= 3'd7;
                    if (ss_fall) begin
                        state  <= S_LOAD;
                        cpol_r <= cpol_i;
                        cpha_r <= cpha_i;
                    end
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care outside the valid window
    always_ff @(posedge clk_i) begin
        if (tx_push_ok) tx_mem[tx_wr] <= tx_dat_i;
        if (rx_push_ok) rx_mem[rx_wr] <= rx_byte;
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {tx_wr, tx_rd, rx_wr, rx_rd} <= 8'h00;
            tx_cnt <= 3'd0;
            rx_cnt <= 3'd0;
        end else if (!spe_i) begin
            {tx_wr, tx_rd, rx_wr, rx_rd} <= 8'h00;
            tx_cnt <= 3'd0;
            rx_cnt <= 3'd0;
        end else begin
            if (tx_push_ok) tx_wr <= tx_wr + 2'd1;
            if (tx_pop_ok)  tx_rd <= tx_rd + 2'd1;
            if (rx_push_ok) rx_wr <= rx_wr + 2'd1;
            if (rx_pop_ok)  rx_rd <= rx_rd + 2'd1;
            tx_cnt <= tx_cnt + {2'b00, tx_push_ok} - {2'b00, tx_pop_ok};
            rx_cnt <= rx_cnt + {2'b00, rx_push_ok} - {2'b00, rx_pop_ok};
        end
    end

    // Interrupt count and sticky status; a set event beats clr_i
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tcnt     <= 2'd0;
            tcnt_vld <= 1'b0;
            {irq_o, rx_ovf_o, tx_udr_o, wcol_o} <= 4'b0000;
        end else if (!spe_i) begin
            tcnt     <= 2'd0;
            tcnt_vld <= 1'b0;
            {irq_o, rx_ovf_o, tx_udr_o, wcol_o} <= 4'b0000;
        end else begin
            if (byte_done) begin
                tcnt_vld <= 1'b1;
                tcnt     <= (tcnt_eff == 2'd0) ? icnt_i : tcnt_eff - 2'd1;
            end
            if (byte_done && tcnt_eff == 2'd0) irq_o <= 1'b1;
            else if (clr_i)                    irq_o <= 1'b0;
            if (byte_done && !rx_push_ok)      rx_ovf_o <= 1'b1;
            else if (clr_i)                    rx_ovf_o <= 1'b0;
            if (tx_pop && !tx_have)            tx_udr_o <= 1'b1;
            else if (clr_i)                    tx_udr_o <= 1'b0;
            if (tx_we_i && !tx_push_ok)        wcol_o <= 1'b1;
            else if (clr_i)                    wcol_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: plays the SPI master with 8-clock SCK phases
// and checks serial data, FIFO contents and status flags against
// hand-computed values.
module tb_spi_slave;

    localparam int PH = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       spe_i = 1'b0;
    logic       cpol_i = 1'b0, cpha_i = 1'b0;
    logic [1:0] icnt_i = 2'd0;
    logic       sck_i = 1'b0, ss_n_i = 1'b1, mosi_i = 1'b0;
    logic       miso_o, miso_oe_o;
    logic [7:0] tx_dat_i = 8'h00;
    logic       tx_we_i = 1'b0;
    logic       tx_full_o;
    logic [7:0] rx_dat_o;
    logic       rx_re_i = 1'b0;
    logic       rx_empty_o;
    logic       clr_i = 1'b0;
    logic       irq_o, rx_ovf_o, tx_udr_o, wcol_o;
    logic [1:0] state_o;
    logic [2:0] bcnt_o;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] got;

    // clock and DUT
    always #5 clk_i = ~clk_i;

    spi_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .spe_i(spe_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .icnt_i(icnt_i), .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_dat_i(tx_dat_i), .tx_we_i(tx_we_i),
        .tx_full_o(tx_full_o), .rx_dat_o(rx_dat_o), .rx_re_i(rx_re_i),
        .rx_empty_o(rx_empty_o), .clr_i(clr_i), .irq_o(irq_o), .rx_ovf_o(rx_ovf_o),
        .tx_udr_o(tx_udr_o), .wcol_o(wcol_o), .state_o(state_o), .bcnt_o(bcnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic tx_push(input logic [7:0] d);
        @(negedge clk_i);
        tx_dat_i = d;
        tx_we_i  = 1'b1;
        @(negedge clk_i);
        tx_we_i  = 1'b0;
    endtask

    task automatic rx_pop();
        @(negedge clk_i);
        rx_re_i = 1'b1;
        @(negedge clk_i);
        rx_re_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk_i);
        spe_i = 1'b0;
        @(negedge clk_i);
        spe_i = 1'b1;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol_i = pol;
        cpha_i = pha;
        sck_i  = pol;
        wait_clk(PH);
    endtask

    task automatic select();
        @(negedge clk_i);
        ss_n_i = 1'b0;
        wait_clk(PH);
    endtask

    task automatic deselect();
        wait_clk(PH);
        ss_n_i = 1'b1;
        wait_clk(PH);
    endtask

    // Master side of nbits bits, MSB first; returns what was seen on MISO
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha_i) begin
                mosi_i = mo[i];
                wait_clk(PH);
                mi[i] = miso_o;
                sck_i = ~cpol_i;
                wait_clk(PH);
                sck_i = cpol_i;
            end else begin
                wait_clk(PH);
                sck_i  = ~cpol_i;
                mosi_i = mo[i];
                wait_clk(PH);
                mi[i] = miso_o;
                sck_i = cpol_i;
            end
        end
        wait_clk(PH);
    endtask

    initial begin
        // reset values
        wait_clk(3);
        #1;
        check("rst_state", state_o, 2'd0);
        check("rst_bcnt", bcnt_o, 3'd7);
        check("rst_miso", miso_o, 1'b0);
        check("rst_oe", miso_oe_o, 1'b0);
        check("rst_full", tx_full_o, 1'b0);
        check("rst_empty", rx_empty_o, 1'b1);
        check("rst_rxdat", rx_dat_o, 8'h00);
        check("rst_flags", {irq_o, rx_ovf_o, tx_udr_o, wcol_o}, 4'b0000);
        rst_i = 1'b1;
        spe_i = 1'b1;
        wait_clk(2);

        // mode 0 single byte, icnt=0
        set_mode(1'b0, 1'b0);
        tx_push(8'hA5);
        select();
        check("m0_oe", miso_oe_o, 1'b1);
        xfer(8'h3C, 8, got);
        check("m0_miso", got, 8'hA5);
        deselect();
        check("m0_oe_off", miso_oe_o, 1'b0);
        check("m0_rx", rx_dat_o, 8'h3C);
        check("m0_empty", rx_empty_o, 1'b0);
        check("m0_irq", irq_o, 1'b1);
        check("m0_udr", tx_udr_o, 1'b1);
        rx_pop();
        check("m0_pop_empty", rx_empty_o, 1'b1);
        pulse_clr();
        check("m0_clr", {irq_o, tx_udr_o}, 2'b00);

        // modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            tx_push(8'h81);
            select();
            xfer(8'h7E, 8, got);
            check($sformatf("mode%0d_miso", m), got, 8'h81);
            deselect();
            check($sformatf("mode%0d_rx", m), rx_dat_o, 8'h7E);
            check($sformatf("mode%0d_irq", m), irq_o, 1'b1);
            rx_pop();
            pulse_clr();
        end

        // icnt=2 burst of three bytes
        icnt_i = 2'd2;
        flush();
        set_mode(1'b0, 1'b0);
        tx_push(8'h11);
        tx_push(8'h22);
        tx_push(8'h33);
        select();
        xfer(8'h01, 8, got);
        check("burst_miso1", got, 8'h11);
        check("burst_irq1", irq_o, 1'b0);
        xfer(8'h02, 8, got);
        check("burst_miso2", got, 8'h22);
        check("burst_irq2", irq_o, 1'b0);
        xfer(8'h03, 8, got);
        check("burst_miso3", got, 8'h33);
        check("burst_irq3", irq_o, 1'b1);
        deselect();
        check("burst_rx1", rx_dat_o, 8'h01);
        rx_pop();
        check("burst_rx2", rx_dat_o, 8'h02);
        rx_pop();
        check("burst_rx3", rx_dat_o, 8'h03);
        rx_pop();
        check("burst_drained", rx_empty_o, 1'b1);

        // TX underflow and RX overflow
        flush();
        select();
        for (int b = 0; b < 5; b++) begin
            xfer(8'h10 + 8'(b), 8, got);
            check($sformatf("udr_miso%0d", b), got, 8'h00);
        end
        deselect();
        check("udr_flag", tx_udr_o, 1'b1);
        check("ovf_flag", rx_ovf_o, 1'b1);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("ovf_rx%0d", b), rx_dat_o, 8'h10 + 8'(b));
            rx_pop();
        end
        check("ovf_empty", rx_empty_o, 1'b1);

        // TX write collision
        for (int b = 0; b < 4; b++) tx_push(8'hE0 + 8'(b));
        check("wcol_full", tx_full_o, 1'b1);
        check("wcol_pre", wcol_o, 1'b0);
        tx_push(8'hEE);
        check("wcol_set", wcol_o, 1'b1);

        // aborted byte then clean 0x55
        flush();
        select();
        xfer(8'hAA, 5, got);
        deselect();
        check("abort_empty", rx_empty_o, 1'b1);
        check("abort_bcnt", bcnt_o, 3'd7);
        check("abort_idle", state_o, 2'd0);
        tx_push(8'h3A);
        select();
        xfer(8'h55, 8, got);
        check("after_abort_miso", got, 8'h3A);
        deselect();
        check("after_abort_rx", rx_dat_o, 8'h55);
        rx_pop();

        // reset mid-byte
        flush();
        tx_push(8'h99);
        select();
        xfer(8'hF0, 4, got);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mid_rst_state", state_o, 2'd0);
        check("mid_rst_miso", miso_o, 1'b0);
        check("mid_rst_oe", miso_oe_o, 1'b0);
        check("mid_rst_empty", rx_empty_o, 1'b1);
        check("mid_rst_full", tx_full_o, 1'b0);
        check("mid_rst_flags", {irq_o, rx_ovf_o, tx_udr_o, wcol_o}, 4'b0000);
        ss_n_i = 1'b1;
        sck_i  = cpol_i;
        wait_clk(4);
        rst_i = 1'b1;
        wait_clk(PH);
        tx_push(8'hC3);
        select();
        xfer(8'hC3, 8, got);
        check("post_rst_miso", got, 8'hC3);
        deselect();
        check("post_rst_rx", rx_dat_o, 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
